// File: rtl/score4_move_driver.sv
// score4_move_driver: turns a target-column request into timed left/right/put button presses
// for the score4 game controller, tracking the game cursor and reporting rejected moves.
module score4_move_driver #(
   parameter int PRESS_CYC = 2,
   parameter int GAP_CYC   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [2:0] req_col,
   output logic       req_ready,
   input  logic       halted,
   input  logic       sync_home,
   input  logic       invalid_move,
   output logic       left,
   output logic       right,
   output logic       put,
   output logic       done,
   output logic       resp_invalid,
   output logic [2:0] cursor
);
   typedef enum logic [2:0] {IDLE, CALC, BTN_HI, BTN_LO, PUT_HI, PUT_LO, DONE} state_t;
   state_t state, state_n;
   logic [2:0] col;
   logic [3:0] cnt, sum, d;
   logic [1:0] moves, moves_calc;
   logic dir_left, pending, sticky, bad_col, cnt_zero;

   assign req_ready    = state == IDLE && !halted;
   assign left         = state == BTN_HI && dir_left;
   assign right        = state == BTN_HI && !dir_left;
   assign put          = state == PUT_HI;
   assign done         = state == DONE;
   assign resp_invalid = done && sticky;

   always_comb begin
      sum        = {1'b0, col} + 4'd7 - {1'b0, cursor};
      d          = sum >= 4'd7 ? sum - 4'd7 : sum;
      moves_calc = d >= 4'd4 ? 2'(4'd7 - d) : d[1:0];
      bad_col    = col == 3'd7;
      cnt_zero   = cnt == 4'd0;
      state_n    = state;
      case (state)
         IDLE:    state_n = req_valid && req_ready ? CALC : IDLE;
         // a rejected column lingers one extra CALC cycle so done lands two edges after acceptance
         CALC:    state_n = bad_col ? (cnt_zero ? CALC : DONE) : (moves_calc != 2'd0 ? BTN_HI : PUT_HI);
         BTN_HI:  state_n = cnt_zero ? BTN_LO : BTN_HI;
         BTN_LO:  state_n = cnt_zero ? (moves != 2'd0 ? BTN_HI : PUT_HI) : BTN_LO;
         PUT_HI:  state_n = cnt_zero ? PUT_LO : PUT_HI;
         PUT_LO:  state_n = cnt_zero ? DONE : PUT_LO;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 4'd0;
         col      <= 3'd0;
         moves    <= 2'd0;
         dir_left <= 1'b0;
         sticky   <= 1'b0;
         pending  <= 1'b0;
         cursor   <= 3'd0;
      end else begin
         cnt <= state_n != state ?
                   (state_n == BTN_HI || state_n == PUT_HI ? 4'(PRESS_CYC - 1) :
                    state_n == BTN_LO || state_n == PUT_LO ? 4'(GAP_CYC - 1) : 4'd0) :
                state == CALC ? 4'd1 : cnt - 4'd1;
         if (state == IDLE && state_n == CALC) col <= req_col;
         if (state == CALC) begin
            moves    <= moves_calc;
            dir_left <= d >= 4'd4;
         end
         if (state == CALC && bad_col) sticky <= 1'b1;
         else if (state_n == PUT_HI && state != PUT_HI) sticky <= 1'b0;
         else if (state == PUT_LO && invalid_move) sticky <= 1'b1;
         if (state == IDLE) begin
            if (sync_home) cursor <= 3'd0;
         end else if (state == DONE) begin
            if (pending || sync_home) cursor <= 3'd0;
            pending <= 1'b0;
         end else begin
            if (sync_home) pending <= 1'b1;
            if (state == BTN_HI && state_n == BTN_LO) begin
               moves  <= moves - 2'd1;
               cursor <= dir_left ? (cursor == 3'd0 ? 3'd6 : cursor - 3'd1)
                                  : (cursor == 3'd6 ? 3'd0 : cursor + 3'd1);
            end
         end
      end
   end
endmodule

// File: tb/tb_score4_move_driver.sv
// tb_score4_move_driver: drives move requests and compares the button waveform, latency,
// response and cursor against a cycle-level model derived from the move rules.
module tb_score4_move_driver;
   localparam int P = 2;
   localparam int G = 4;
   logic clk = 1'b0;
   logic rst, req_valid, halted, sync_home, invalid_move;
   logic [2:0] req_col;
   logic req_ready, left, right, put, done, resp_invalid;
   logic [2:0] cursor;
   int tests = 0;
   int fails = 0;
   int mcur = 0;

   score4_move_driver #(.PRESS_CYC(P), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_col(req_col), .req_ready(req_ready),
      .halted(halted), .sync_home(sync_home), .invalid_move(invalid_move), .left(left),
      .right(right), .put(put), .done(done), .resp_invalid(resp_invalid), .cursor(cursor)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One request; the expected waveform is built from the press/gap timing rules.
   task automatic run_req(input int col, input bit inv, input bit sync_mid, input bit sync_idle,
                          input string name);
      int n, d, len, kf, badk;
      bit dl, bad, mism, exp_inv;
      logic [3:0] expv, got, badg, bade;
      bad = col > 6;
      if (sync_idle) mcur = 0;
      d = (col - mcur + 7) % 7;
      dl = d >= 4;
      n = dl ? 7 - d : d;
      len = bad ? 2 : 1 + (n + 1) * (P + G);
      kf = n * (P + G) + P + 1;
      exp_inv = bad || inv;
      mism = 0; badk = 0; badg = 0; bade = 0;
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s ready: got %b want 1", name, req_ready);
      end
      req_col = 3'(col);
      req_valid = 1'b1;
      sync_home = sync_idle;
      for (int k = 0; k <= len + 1; k++) begin
         tick;
         req_valid = 1'b0;
         sync_home = sync_mid && k == 3;
         halted = sync_mid && k >= 2 && k <= 5;
         invalid_move = inv && k == kf + 2;
         expv = 4'b0000;
         if (k == len) expv = 4'b0001;
         else if (!bad && k >= 1 && k < len && (k - 1) % (P + G) < P)
            expv = (k - 1) / (P + G) < n ? (dl ? 4'b1000 : 4'b0100) : 4'b0010;
         got = {left, right, put, done};
         if (got !== expv && !mism) begin
            mism = 1; badk = k; badg = got; bade = expv;
         end
         if (k == len) begin
            tests++;
            if (resp_invalid !== exp_inv) begin
               fails++;
               $display("FAIL %s resp_invalid: got %b want %b", name, resp_invalid, exp_inv);
            end
         end
      end
      tests++;
      if (mism) begin
         fails++;
         $display("FAIL %s trace at cycle %0d: got lrpd=%b want %b", name, badk, badg, bade);
      end
      if (!bad) mcur = col;
      if (sync_mid) mcur = 0;
      tests++;
      if (cursor !== 3'(mcur)) begin
         fails++;
         $display("FAIL %s cursor: got %0d want %0d", name, cursor, mcur);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 0; req_col = 0; halted = 0; sync_home = 0; invalid_move = 0;
      tick;
      tick;
      tests++;
      if ({left, right, put, done, resp_invalid, cursor, req_ready} !== 9'b000000001) begin
         fails++;
         $display("FAIL reset outputs: got %b want 000000001",
                  {left, right, put, done, resp_invalid, cursor, req_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      mcur = 0;
   endtask

   task automatic test_directed;
      run_req(2, 0, 0, 0, "right2");
      sync_home = 1'b1;
      tick;
      sync_home = 1'b0;
      mcur = 0;
      tests++;
      if (cursor !== 3'd0) begin
         fails++;
         $display("FAIL sync_idle cursor: got %0d want 0", cursor);
      end
      run_req(5, 0, 0, 0, "left2");
      run_req(3, 0, 0, 0, "to3");
      run_req(3, 0, 0, 0, "put_only");
      run_req(7, 0, 0, 0, "bad_col");
      run_req(6, 1, 0, 0, "invalid_put");
   endtask

   task automatic test_sync_home;
      run_req(1, 0, 0, 0, "to1");
      run_req(4, 0, 1, 0, "sync_mid");
      run_req(2, 0, 0, 0, "after_sync");
      run_req(5, 0, 0, 1, "sync_with_req");
   endtask

   task automatic test_halted;
      bit seen;
      halted = 1'b1;
      req_col = 3'd3;
      req_valid = 1'b1;
      seen = 0;
      tick;
      tests++;
      if (req_ready !== 1'b0) begin
         fails++;
         $display("FAIL halted ready: got %b want 0", req_ready);
      end
      for (int k = 0; k < 6; k++) begin
         tick;
         if (left || right || put || done) seen = 1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL halted activity: got 1 want 0");
      end
      req_valid = 1'b0;
      halted = 1'b0;
      tick;
   endtask

   task automatic test_random;
      for (int i = 0; i < 20; i++) begin
         int c;
         c = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
         run_req(c, $urandom_range(0, 2) == 0, 0, $urandom_range(0, 5) == 0, "random");
         repeat ($urandom_range(0, 2)) tick;
      end
   endtask

   task automatic test_async_reset;
      req_col = 3'((mcur + 2) % 7);
      req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      tick;
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({left, right, put, cursor} !== 6'b000000) begin
         fails++;
         $display("FAIL async_reset: got lrp/cursor=%b want 000000", {left, right, put, cursor});
      end
      @(negedge clk);
      rst = 1'b0;
      mcur = 0;
      run_req(4, 0, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset;
      test_directed;
      test_sync_home;
      test_halted;
      test_random;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
